// File: rtl/inst_fetch_axi_bridge.sv
// Instruction-fetch bridge: turns a PC-stage fetch request into a single-beat
// AXI-Lite read and returns the word with a one-cycle valid pulse.
module inst_fetch_axi_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  ce,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  fetch_err,
  output logic                  stall,
  output logic [31:0]           fetch_count,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
  state_t state;

  // Instruction access, secure, unprivileged.
  assign arprot = 3'b100;
  assign stall  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      inst_valid  <= 1'b0;
      fetch_err   <= 1'b0;
      inst        <= '0;
      araddr      <= '0;
      fetch_count <= '0;
    end else begin
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ce) begin
            if (pc[1:0] == 2'b00) begin
              araddr  <= pc;
              arvalid <= 1'b1;
              state   <= ADDR;
            end else begin
              state <= ERR;
            end
          end
        end
        ADDR: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (rvalid && rready) begin
            rready      <= 1'b0;
            // A failed response returns a NOP so the pipeline never sees slave garbage.
            inst        <= (rresp == 2'b00) ? rdata : '0;
            fetch_err   <= (rresp != 2'b00);
            inst_valid  <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
            state       <= IDLE;
          end
        end
        ERR: begin
          inst        <= '0;
          inst_valid  <= 1'b1;
          fetch_err   <= 1'b1;
          fetch_count <= fetch_count + 32'd1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_axi_bridge.sv
// Directed self-checking bench for inst_fetch_axi_bridge.
module tb_inst_fetch_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_err;
  logic        stall;
  logic [31:0] fetch_count;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [31:0] rdata_drv;
  logic        slave_echo;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  // Streaming slave returns a word derived from the address it was asked for.
  assign rdata = slave_echo ? (32'hA500_0000 ^ araddr) : rdata_drv;

  inst_fetch_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce),
    .inst(inst), .inst_valid(inst_valid), .fetch_err(fetch_err),
    .stall(stall), .fetch_count(fetch_count),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned k;
    int unsigned last_pulse;
    int unsigned seen;
    int unsigned ar_seen;
    int unsigned stall_seen;

    rst = 1'b1; ce = 1'b0; pc = '0; arready = 1'b0; rvalid = 1'b0;
    rdata_drv = '0; rresp = 2'b00; slave_echo = 1'b0;
    tick(); tick();
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_fetch_err", fetch_err, 0);
    check("rst_inst", inst, 0);
    check("rst_araddr", araddr, 0);
    check("rst_count", fetch_count, 0);
    check("rst_stall", stall, 0);
    check("arprot", arprot, 3'b100);
    rst = 1'b0;
    tick();

    // Zero-wait slave
    arready = 1'b1; rvalid = 1'b1; rdata_drv = 32'h2401_0005; rresp = 2'b00;
    ce = 1'b1; pc = 32'h0;
    tick();
    ce = 1'b0;
    check("zw_arvalid", arvalid, 1);
    check("zw_araddr", araddr, 32'h0);
    check("zw_stall", stall, 1);
    check("zw_noearly", inst_valid, 0);
    tick();
    check("zw_rready", rready, 1);
    check("zw_ar_drop", arvalid, 0);
    check("zw_noearly2", inst_valid, 0);
    tick();
    check("zw_valid", inst_valid, 1);
    check("zw_inst", inst, 32'h2401_0005);
    check("zw_err", fetch_err, 0);
    check("zw_count", fetch_count, 1);
    check("zw_idle", stall, 0);
    tick();
    check("zw_pulse", inst_valid, 0);
    check("zw_hold", inst, 32'h2401_0005);

    // Misaligned fetch: no AXI traffic, NOP with error one edge after ERR entry
    arready = 1'b0; rvalid = 1'b0;
    ce = 1'b1; pc = 32'h6;
    tick();
    ce = 1'b0;
    check("mis_arvalid", arvalid, 0);
    check("mis_stall", stall, 1);
    check("mis_noearly", inst_valid, 0);
    tick();
    check("mis_valid", inst_valid, 1);
    check("mis_err", fetch_err, 1);
    check("mis_inst", inst, 0);
    check("mis_arvalid2", arvalid, 0);
    check("mis_count", fetch_count, 2);
    check("mis_idle", stall, 0);
    tick();
    check("mis_pulse", inst_valid, 0);
    check("mis_err_pulse", fetch_err, 0);

    // Backpressure: arready low for 3 cycles, rvalid delayed 2
    ce = 1'b1; pc = 32'h4; rdata_drv = 32'h8C22_0000;
    tick();
    ce = 1'b0; pc = 32'hFFF0;
    for (int i = 0; i < 4; i++) begin
      check("bp_arvalid", arvalid, 1);
      check("bp_araddr", araddr, 32'h4);
      check("bp_stall", stall, 1);
      if (i == 3) arready = 1'b1;
      tick();
    end
    arready = 1'b0;
    check("bp_rready", rready, 1);
    check("bp_ar_drop", arvalid, 0);
    for (int i = 0; i < 2; i++) begin
      check("bp_wait", inst_valid, 0);
      check("bp_stall2", stall, 1);
      if (i == 1) rvalid = 1'b1;
      tick();
    end
    rvalid = 1'b0;
    check("bp_valid", inst_valid, 1);
    check("bp_inst", inst, 32'h8C22_0000);
    check("bp_count", fetch_count, 3);
    tick();

    // Reset while in DATA, then a stale R beat
    arready = 1'b1; ce = 1'b1; pc = 32'h10; rdata_drv = 32'h1111_2222;
    tick();
    ce = 1'b0;
    tick();
    check("rd_rready_pre", rready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rd_rready", rready, 0);
    check("rd_stall", stall, 0);
    check("rd_count", fetch_count, 0);
    rvalid = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (inst_valid) seen++;
    end
    check("rd_no_pulse", seen, 0);
    check("rd_count2", fetch_count, 0);

    // Streaming with a zero-wait slave
    slave_echo = 1'b1; arready = 1'b1; rvalid = 1'b1; rresp = 2'b00;
    pc = 32'h0; ce = 1'b1;
    k = 0; last_pulse = 0;
    for (int cyc = 1; cyc <= 40 && k < 4; cyc++) begin
      tick();
      if (arvalid) check("st_araddr", araddr, 32'(4 * k));
      if (inst_valid) begin
        check("st_inst", inst, 32'hA500_0000 ^ 32'(4 * k));
        if (k > 0) check("st_spacing", cyc - last_pulse, 3);
        last_pulse = cyc;
        k++;
        pc = 32'(4 * k);
        if (k == 4) ce = 1'b0;
      end
    end
    check("st_pulses", k, 4);
    check("st_count", fetch_count, 4);
    ar_seen = 0; stall_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (arvalid) ar_seen++;
      if (stall) stall_seen++;
    end
    check("st_quiet_ar", ar_seen, 0);
    check("st_quiet_stall", stall_seen, 0);
    slave_echo = 1'b0;

    // Slave error response
    rdata_drv = 32'hDEAD_BEEF; rresp = 2'b10; pc = 32'h8; ce = 1'b1;
    tick();
    ce = 1'b0;
    tick();
    tick();
    check("se_valid", inst_valid, 1);
    check("se_inst", inst, 0);
    check("se_err", fetch_err, 1);
    check("se_count", fetch_count, 5);
    check("se_idle", stall, 0);
    tick();
    check("se_pulse", inst_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
